aes_iter_core: RTL and testbench

- Iterative AES block-cipher core: one round per clock, sharing one S-box bank, ShiftRows/MixColumns datapath and AddRoundKey.
- Generalised over key length (128/192/256). Encrypt or decrypt is selectable per block.
- Replaces the fixed encrypt-then-decrypt AES-128 sequencer. Keys are expanded once into a round-key store and reused for any number of blocks.
- Valid/ready handshakes on key, input and output. Sits between the host bus adapter and the stream buffers.

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/aes_key_expand_iter.sv | 88 ++++++++
 rtl/aes_round_ops.sv | 81 ++++++++
 rtl/aes_iter_core.sv | 134 +++++++++++++
 tb/tb_aes_iter_core.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: mode and FSM encodings, key-schedule constants and GF(2^8) helpers.
package aes_pkg;

  typedef enum logic { ENC = 1'b0, DEC = 1'b1 } mode_e;

  typedef enum logic [2:0] { IDLE, KEXP, READY, ROUND, OUT } state_e;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic int nk_of(input int key_len);
    return key_len / 32;
  endfunction

  function automatic int nr_of(input int key_len);
    return key_len / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse; it maps 0 to 0, which is what the S-box needs
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {aff_fwd(ginv(w[31:24])), aff_fwd(ginv(w[23:16])),
            aff_fwd(ginv(w[15:8])),  aff_fwd(ginv(w[7:0]))};
  endfunction

endpackage

// File: rtl/aes_key_expand_iter.sv
// Iterative key schedule: one word per cycle into a 4*(NR+1) x 32 store, read back four words at a time.
module aes_key_expand_iter
  import aes_pkg::*;
#(
  parameter int KEY_LEN = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [255:0] key_i,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_key_o,
  output logic         expand_done_o
);
  localparam int NK = nk_of(KEY_LEN);
  localparam int NR = nr_of(KEY_LEN);
  localparam int NW = 4 * (NR + 1);

  logic [31:0] w_q [NW];
  logic [5:0]  i_q, i_d;
  logic [2:0]  k_q, k_d;
  logic [3:0]  rc_q, rc_d;
  logic        busy_q, busy_d;
  logic [31:0] prev, tmp, new_w;
  logic [5:0]  rd_base;
  logic        unused_key_bits;

  assign unused_key_bits = ^key_i;

  // k_q tracks i mod NK and rc_q tracks i/NK - 1, avoiding a divider for NK = 6
  always_comb begin
    prev = w_q[i_q - 6'd1];
    tmp  = prev;
    if (k_q == 3'd0) begin
      tmp = sub_word({prev[23:0], prev[31:24]}) ^ {RCON[rc_q], 24'h0};
    end else if (NK == 8 && k_q == 3'd4) begin
      tmp = sub_word(prev);
    end
    new_w = w_q[i_q - 6'(NK)] ^ tmp;
  end

  assign expand_done_o = busy_q && (i_q == 6'(NW - 1));

  always_comb begin
    busy_d = busy_q;
    i_d    = i_q;
    k_d    = k_q;
    rc_d   = rc_q;
    if (load_i) begin
      busy_d = 1'b1;
      i_d    = 6'(NK);
      k_d    = 3'd0;
      rc_d   = 4'd0;
    end else if (busy_q) begin
      i_d = i_q + 6'd1;
      k_d = (k_q == 3'(NK - 1)) ? 3'd0 : k_q + 3'd1;
      if (k_q == 3'd0) rc_d = rc_q + 4'd1;
      if (expand_done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      i_q    <= '0;
      k_q    <= '0;
      rc_q   <= '0;
    end else begin
      busy_q <= busy_d;
      i_q    <= i_d;
      k_q    <= k_d;
      rc_q   <= rc_d;
    end
  end

  // Store is deliberately not reset; validity is tracked by the owner
  always_ff @(posedge clk) begin
    if (load_i) begin
      for (int j = 0; j < NK; j++) w_q[j] <= key_i[255-32*j -: 32];
    end else if (busy_q) begin
      w_q[i_q] <= new_w;
    end
  end

  assign rd_base  = {rd_idx_i, 2'b00};
  assign rd_key_o = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};

endmodule

// File: rtl/aes_round_ops.sv
// Round transforms on a 128-bit state, byte 0 at [127:120], column-major (byte = row + 4*col).
module sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic         inv_i,
  output logic [127:0] state_o
);
  // Forward and inverse S-boxes share one field inverter per byte; only the affine step differs
  for (genvar b = 0; b < 16; b++) begin : g_byte
    logic [7:0] x;
    logic [7:0] y;
    assign x = inv_i ? aff_inv(state_i[8*b +: 8]) : state_i[8*b +: 8];
    assign y = ginv(x);
    assign state_o[8*b +: 8] = inv_i ? y : aff_fwd(y);
  end
endmodule

module shift_rows (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign state_o[127-8*(r+4*c) -: 8] = state_i[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end
endmodule

module inv_shift_rows (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign state_o[127-8*(r+4*c) -: 8] = state_i[127-8*(r+4*((c+4-r)%4)) -: 8];
    end
  end
endmodule

module mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = state_i[127-32*c -: 32];
    assign state_o[127-32*c -: 32] = {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  end
endmodule

module inv_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = state_i[127-32*c -: 32];
    assign state_o[127-32*c -: 32] = {
      gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
      gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
      gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
      gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  end
endmodule

module add_round_key (
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic [127:0] state_o
);
  assign state_o = state_i ^ key_i;
endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 enc/dec, one round per clock; result NR edges after accept.
// Output is held under out_ready backpressure; no new key or block is taken until it drains.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_LEN = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key_in,
  output logic         key_loaded,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_mode
);
  localparam int         NR  = nr_of(KEY_LEN);
  localparam logic [3:0] NR4 = 4'(NR);

  state_e       state_q, state_d;
  mode_e        mode_q, mode_d;
  logic [3:0]   r_q, r_d;
  logic [127:0] data_q, data_d;
  logic         kl_q, kl_d;

  logic         key_hs, in_hs, expand_done, last, dec;
  logic [3:0]   rd_idx;
  logic [127:0] rk, rk_imc, sb, sr, isr, mc, imc, ark_a, ark_k, ark_o;

  assign key_ready  = (state_q == IDLE) || (state_q == READY);
  assign in_ready   = (state_q == READY) && !key_valid && kl_q;
  assign out_valid  = (state_q == OUT);
  assign key_loaded = kl_q;
  assign out_data   = data_q;
  assign out_mode   = mode_q;

  assign key_hs = key_valid && key_ready;
  assign in_hs  = in_valid && in_ready;
  assign last   = (r_q == NR4);
  assign dec    = (mode_q == DEC);

  // Decrypt walks the schedule backwards; on accept the direction comes from the incoming block
  assign rd_idx = (state_q == ROUND) ? (dec ? NR4 - r_q : r_q)
                                     : (in_mode ? NR4 : 4'd0);

  aes_key_expand_iter #(.KEY_LEN(KEY_LEN)) u_kexp (
    .clk           (clk),
    .rst_n         (rst),
    .load_i        (key_hs),
    .key_i         (key_in),
    .rd_idx_i      (rd_idx),
    .rd_key_o      (rk),
    .expand_done_o (expand_done)
  );

  sub_bytes       u_sb   (.state_i(data_q), .inv_i(dec), .state_o(sb));
  shift_rows      u_sr   (.state_i(sb),  .state_o(sr));
  inv_shift_rows  u_isr  (.state_i(sb),  .state_o(isr));
  mix_columns     u_mc   (.state_i(sr),  .state_o(mc));
  inv_mix_columns u_imc  (.state_i(isr), .state_o(imc));
  inv_mix_columns u_kimc (.state_i(rk),  .state_o(rk_imc));

  assign ark_a = (state_q != ROUND) ? in_data
               : last ? (dec ? isr : sr)
                      : (dec ? imc : mc);
  assign ark_k = (state_q == ROUND && dec && !last) ? rk_imc : rk;

  add_round_key u_ark (.state_i(ark_a), .key_i(ark_k), .state_o(ark_o));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    r_d     = r_q;
    data_d  = data_q;
    kl_d    = kl_q;
    unique case (state_q)
      IDLE: begin
        if (key_hs) begin
          state_d = KEXP;
          kl_d    = 1'b0;
        end
      end
      KEXP: begin
        if (expand_done) begin
          state_d = READY;
          kl_d    = 1'b1;
        end
      end
      READY: begin
        if (key_hs) begin
          state_d = KEXP;
          kl_d    = 1'b0;
        end else if (in_hs) begin
          data_d  = ark_o;
          mode_d  = mode_e'(in_mode);
          r_d     = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d = ark_o;
        if (last) state_d = OUT;
        else      r_d     = r_q + 4'd1;
      end
      OUT: begin
        if (out_ready) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= ENC;
      r_q     <= '0;
      data_q  <= '0;
      kl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
      data_q  <= data_d;
      kl_q    <= kl_d;
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: one instance per key length, FIPS-197 vectors plus handshake/reset corner cases.
module tb_aes_iter_core;

  localparam logic [127:0] K128A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PTB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEYA  = {K128A, 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5};
  localparam logic [255:0] KEYB  = {K128B, 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a};
  localparam logic [255:0] KEYC  = {K192, 64'hffffffffffffffff};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         key_valid [3], key_ready [3], key_loaded [3];
  logic         in_valid [3], in_ready [3], in_mode [3];
  logic         out_valid [3], out_ready [3], out_mode [3];
  logic [255:0] key_in [3];
  logic [127:0] in_data [3], out_data [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_iter_core #(.KEY_LEN(128 + 64 * g)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid[g]),
      .key_ready  (key_ready[g]),
      .key_in     (key_in[g]),
      .key_loaded (key_loaded[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_data    (in_data[g]),
      .in_mode    (in_mode[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_data   (out_data[g]),
      .out_mode   (out_mode[g])
    );
  end

  typedef struct {
    int           inst;
    logic [255:0] key;
    logic         mode;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  typedef struct {
    int           inst;
    logic [127:0] data;
    logic         mode;
  } exp_t;

  exp_t         sb[$];
  vec_t         vecs [8];
  logic [255:0] cur_key [3];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_key(input int k, input logic [255:0] key);
    int n;
    @(negedge clk);
    key_valid[k] = 1'b1;
    key_in[k]    = key;
    #1;
    n = 0;
    while (!key_ready[k] && n < 100) begin @(negedge clk); #1; n++; end
    chk($sformatf("key_ready_wait%0d", k), 128'(key_ready[k]), 128'd1);
    @(posedge clk); #1;
    key_valid[k] = 1'b0;
    chk($sformatf("key_loaded_drop%0d", k), 128'(key_loaded[k]), 128'd0);
    n = 0;
    while (!key_loaded[k] && n < 100) begin @(posedge clk); #1; n++; end
    chk($sformatf("kexp_cycles%0d", k), 128'(n), 128'(4 * (10 + 2 * k + 1) - (4 + 2 * k)));
    cur_key[k] = key;
  endtask

  task automatic issue_block(input int k, input logic [127:0] din, input logic mode,
                             input logic [127:0] dout, input bit expect_out);
    int n;
    exp_t e;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_data[k]  = din;
    in_mode[k]  = mode;
    #1;
    n = 0;
    while (!in_ready[k] && n < 100) begin @(negedge clk); #1; n++; end
    chk($sformatf("in_ready_wait%0d", k), 128'(in_ready[k]), 128'd1);
    if (expect_out) begin
      e.inst = k; e.data = dout; e.mode = mode;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_out(input int k);
    int n;
    exp_t e;
    n = 0;
    while (!out_valid[k] && n < 60) begin @(posedge clk); #1; n++; end
    chk($sformatf("latency%0d", k), 128'(n), 128'(10 + 2 * k));
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard%0d: output with no expected entry, got %h", k, out_data[k]);
    end else begin
      e = sb.pop_front();
      chk($sformatf("out_data%0d", e.inst), out_data[k], e.data);
      chk($sformatf("out_mode%0d", e.inst), 128'(out_mode[k]), 128'(e.mode));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    for (int k = 0; k < 3; k++) begin
      key_valid[k] = 0; key_in[k] = '0; in_valid[k] = 0; in_data[k] = '0;
      in_mode[k] = 0; out_ready[k] = 1; cur_key[k] = '0;
    end
    vecs[0] = '{0, KEYB, 1'b0, PT,    CT128};
    vecs[1] = '{0, KEYB, 1'b1, CT128, PT};
    vecs[2] = '{0, KEYA, 1'b0, PTB,   CTB};
    vecs[3] = '{0, KEYA, 1'b1, CTB,   PTB};
    vecs[4] = '{1, KEYC, 1'b0, PT,    CT192};
    vecs[5] = '{1, KEYC, 1'b1, CT192, PT};
    vecs[6] = '{2, K256, 1'b0, PT,    CT256};
    vecs[7] = '{2, K256, 1'b1, CT256, PT};

    #3 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid",  128'(out_valid[k]), 128'd0);
      chk("rst_out_data",   out_data[k], 128'd0);
      chk("rst_out_mode",   128'(out_mode[k]), 128'd0);
      chk("rst_key_loaded", 128'(key_loaded[k]), 128'd0);
      chk("rst_in_ready",   128'(in_ready[k]), 128'd0);
      chk("rst_key_ready",  128'(key_ready[k]), 128'd1);
    end
    @(negedge clk);
    rst = 1'b1;

    // Block offered before any key: never accepted
    in_valid[0] = 1'b1; in_data[0] = PT;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("idle_in_ready",  128'(in_ready[0]), 128'd0);
      chk("idle_out_valid", 128'(out_valid[0]), 128'd0);
    end
    in_valid[0] = 1'b0;

    for (int v = 0; v < 8; v++) begin
      if (cur_key[vecs[v].inst] !== vecs[v].key) load_key(vecs[v].inst, vecs[v].key);
      issue_block(vecs[v].inst, vecs[v].din, vecs[v].mode, vecs[v].dout, 1'b1);
      wait_out(vecs[v].inst);
    end

    // Backpressure: result held, no key or block taken while stalled
    out_ready[0] = 1'b0;
    issue_block(0, PTB, 1'b0, CTB, 1'b1);
    wait_out(0);
    key_valid[0] = 1'b1; key_in[0] = KEYB;
    in_valid[0]  = 1'b1; in_data[0] = PT; in_mode[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
      chk("bp_out_data",  out_data[0], CTB);
      chk("bp_out_mode",  128'(out_mode[0]), 128'd0);
      chk("bp_in_ready",  128'(in_ready[0]), 128'd0);
      chk("bp_key_ready", 128'(key_ready[0]), 128'd0);
    end
    key_valid[0] = 1'b0; in_valid[0] = 1'b0;
    chk("bp_key_loaded", 128'(key_loaded[0]), 128'd1);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 128'(out_valid[0]), 128'd0);

    // Key and block offered together: key wins, block then uses the new key
    @(negedge clk);
    key_valid[0] = 1'b1; key_in[0] = KEYB;
    in_valid[0]  = 1'b1; in_data[0] = PT; in_mode[0] = 1'b0;
    #1;
    chk("prio_in_ready",  128'(in_ready[0]), 128'd0);
    chk("prio_key_ready", 128'(key_ready[0]), 128'd1);
    @(posedge clk); #1;
    key_valid[0] = 1'b0;
    chk("prio_key_loaded", 128'(key_loaded[0]), 128'd0);
    n = 0;
    while (!key_loaded[0] && n < 100) begin
      chk("prio_in_ready_kexp", 128'(in_ready[0]), 128'd0);
      @(posedge clk); #1;
      n++;
    end
    in_valid[0] = 1'b0;
    chk("prio_kexp_cycles", 128'(n), 128'd40);
    cur_key[0] = KEYB;
    issue_block(0, PT, 1'b0, CT128, 1'b1);
    wait_out(0);

    // Reset while round 5 is in flight
    issue_block(0, CT128, 1'b1, PT, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_out_valid",  128'(out_valid[k]), 128'd0);
      chk("mid_rst_out_data",   out_data[k], 128'd0);
      chk("mid_rst_out_mode",   128'(out_mode[k]), 128'd0);
      chk("mid_rst_key_loaded", 128'(key_loaded[k]), 128'd0);
      chk("mid_rst_in_ready",   128'(in_ready[k]), 128'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid[0] = 1'b1; in_data[0] = PT; in_mode[0] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      chk("post_rst_in_ready",  128'(in_ready[0]), 128'd0);
      chk("post_rst_out_valid", 128'(out_valid[0]), 128'd0);
    end
    in_valid[0] = 1'b0;
    load_key(0, KEYA);
    issue_block(0, PTB, 1'b0, CTB, 1'b1);
    wait_out(0);

    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
